// File: rtl/vx_onehot_mux_pipe_if.sv
// Handshake/bus bundle for the pipelined one-hot mux.
// The master side drives input transfers and output backpressure; the slave side is the mux.
interface vx_onehot_mux_pipe_if #(
   parameter int DATAW = 32,
   parameter int N     = 4,
   parameter int LANES = 1,
   parameter int CNTW  = 16
);
   logic                        valid_in;
   logic                        ready_in;
   logic [N-1:0][DATAW-1:0]     data_in;
   logic [LANES-1:0][N-1:0]     sel_in;
   logic                        valid_out;
   logic                        ready_out;
   logic [LANES-1:0][DATAW-1:0] data_out;
   logic [LANES-1:0]            err_out;
   logic [CNTW-1:0]             err_count;

   modport master (
      output valid_in, data_in, sel_in, ready_out,
      input  ready_in, valid_out, data_out, err_out, err_count
   );

   modport slave (
      input  valid_in, data_in, sel_in, ready_out,
      output ready_in, valid_out, data_out, err_out, err_count
   );
endinterface

// File: rtl/vx_onehot_mux_pipe.sv
// Multi-lane pipelined one-hot mux with elastic valid/ready stages.
// Each lane AND-OR selects from the shared input words and flags selects that
// are not exactly one-hot; accepted transfers with any lane error are counted.

// Per-lane AND-OR mux plus one-hot integrity check.
module vx_onehot_mux_lane #(
   parameter int DATAW = 32,
   parameter int N     = 4
) (
   input  logic [N-1:0][DATAW-1:0] data_i,
   input  logic [N-1:0]            sel_i,
   output logic [DATAW-1:0]        data_o,
   output logic                    err_o
);
   logic any_set;
   logic multi_set;

   // OR of selected words; zero select gives zero, multi-hot ORs words together.
   always_comb begin
      data_o    = '0;
      any_set   = 1'b0;
      multi_set = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (sel_i[i]) data_o = data_o | data_i[i];
         multi_set = multi_set | (any_set & sel_i[i]);
         any_set   = any_set | sel_i[i];
      end
      err_o = !any_set || multi_set;
   end
endmodule

module vx_onehot_mux_pipe #(
   parameter int DATAW  = 32,
   parameter int N      = 4,
   parameter int LANES  = 1,
   parameter int STAGES = 1,
   parameter int CNTW   = 16
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   vx_onehot_mux_pipe_if.slave    bus_io
);
   typedef struct packed {
      logic [LANES-1:0][DATAW-1:0] data;
      logic [LANES-1:0]            err;
   } stage_t;

   logic [LANES-1:0][DATAW-1:0] lane_data;
   logic [LANES-1:0]            lane_err;
   stage_t                      in_s;

   logic [STAGES-1:0] vld_q, vld_d;
   logic [STAGES-1:0] load;   // stage may take new content this cycle
   logic [STAGES-1:0] move;   // a valid transfer actually lands in the stage
   stage_t            stg_q [STAGES];
   stage_t            stg_d [STAGES];
   logic [CNTW-1:0]   err_cnt_q, err_cnt_d;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      vx_onehot_mux_lane #(.DATAW(DATAW), .N(N)) u_lane (
         .data_i (bus_io.data_in),
         .sel_i  (bus_io.sel_in[l]),
         .data_o (lane_data[l]),
         .err_o  (lane_err[l])
      );
   end

   // Pack per-lane results into the stage-0 payload.
   always_comb begin
      in_s      = '0;
      in_s.data = lane_data;
      in_s.err  = lane_err;
   end

   // Ready ripples back from the output; payload registers only change on a real transfer.
   always_comb begin
      load = '0;
      move = '0;
      load[STAGES-1] = !vld_q[STAGES-1] || bus_io.ready_out;
      for (int k = STAGES - 2; k >= 0; k--) begin
         load[k] = !vld_q[k] || load[k+1];
      end
      move[0]  = bus_io.valid_in && load[0];
      vld_d[0] = load[0] ? bus_io.valid_in : vld_q[0];
      stg_d[0] = move[0] ? in_s : stg_q[0];
      for (int k = 1; k < STAGES; k++) begin
         move[k]  = vld_q[k-1] && load[k];
         vld_d[k] = load[k] ? vld_q[k-1] : vld_q[k];
         stg_d[k] = move[k] ? stg_q[k-1] : stg_q[k];
      end
   end

   // Saturating count of accepted transfers carrying any lane error.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (move[0] && (|in_s.err) && (err_cnt_q != {CNTW{1'b1}})) begin
         err_cnt_d = err_cnt_q + 1'b1;
      end
   end

   // Stage valids, payloads and error counter; reset discards everything in flight.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         vld_q     <= '0;
         err_cnt_q <= '0;
         for (int k = 0; k < STAGES; k++) stg_q[k] <= '0;
      end else begin
         vld_q     <= vld_d;
         err_cnt_q <= err_cnt_d;
         for (int k = 0; k < STAGES; k++) stg_q[k] <= stg_d[k];
      end
   end

   assign bus_io.ready_in  = load[0];
   assign bus_io.valid_out = vld_q[STAGES-1];
   assign bus_io.data_out  = stg_q[STAGES-1].data;
   assign bus_io.err_out   = stg_q[STAGES-1].err;
   assign bus_io.err_count = err_cnt_q;
endmodule

// File: doc/vx_onehot_mux_pipe.md
# VX_onehot_mux_pipe

Multi-lane, pipelined one-hot multiplexer with valid/ready flow control and select-integrity checking. Each of LANES output lanes independently picks one of N shared input words using its own one-hot select; results pass through STAGES elastic register stages. It sits between arbiters or crossbar control that produce one-hot grants and the timing-critical wide datapaths they steer, where a purely combinational one-hot mux would close timing poorly. Malformed selects are flagged per lane and counted.

## Interface
- DATAW, 32: width of each input word
- N, 4: number of input words (N >= 1)
- LANES, 1: number of independent output lanes (LANES >= 1)
- STAGES, 1: register stages between input and output (1..4)
- CNTW, 16: width of the error counter
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- valid_in  in  1  input transfer valid
- ready_in  out  1  block can accept an input transfer this cycle
- data_in  in  N*DATAW  input words, word i at [i]
- sel_in  in  LANES*N  one-hot select per lane, lane l at [l]
- valid_out  out  1  output transfer valid
- ready_out  in  1  downstream accepts output transfer
- data_out  out  LANES*DATAW  selected word per lane
- err_out  out  LANES  per-lane select-malformed flag, aligned with data_out
- err_count  out  CNTW  number of accepted transfers with any lane error, saturating

## Operation
- Clocking: one clock; reset is synchronous and active-high.
- Select function per lane l: data = OR over i of (sel_in[l][i] ? data_in[i] : 0). Zero select -> all-zero data; multi-hot select -> bitwise OR of the selected words. The result is deterministic, never X.
- err[l] = 1 when sel_in[l] is not exactly one-hot, i.e. zero bits or two or more bits set. For N == 1, err[l] = !sel_in[l][0].
- Transfer accepted: valid_in && ready_in. Computed data and err bits are captured in stage 0. Stage k+1 takes stage k's contents.
- Elastic pipeline: each stage holds a valid bit. Stage k loads when it is empty or its content is leaving this cycle. ready_in = stage 0 loads. The last stage drives valid_out, data_out and err_out. Its content leaves when valid_out && ready_out.
- Bubbles collapse: an empty stage behind a stalled stage still fills.
- Data and err registers load only when the stage loads. Otherwise they hold their value, including while invalid.
- err_count increments by 1 on every accepted input transfer where any err bit is set, counted at input acceptance. It saturates at 2^CNTW-1 and never wraps.
- Input fields are sampled only at acceptance. Changing data_in or sel_in while ready_in=0 has no effect.

## Timing
- Reset values: all stage valids 0, so valid_out=0; data_out=0; err_out=0; err_count=0. ready_in=1 in the first cycle after reset deasserts.
- Latency: a transfer accepted at edge t appears on valid_out after edge t+STAGES-1, i.e. STAGES cycles from presentation to output, when not stalled.
- Throughput: 1 transfer/cycle with ready_out held at 1. No bubbles at steady state.
- Full: all STAGES valid and ready_out=0 -> ready_in=0 in the same cycle. ready_in is combinational on ready_out through the stage chain. No combinational path exists from valid_in to valid_out.
- Simultaneous accept and output while full: allowed. Occupancy is unchanged and ready_in=1.
- Stalled output: valid_out, data_out and err_out must remain stable until accepted.
- Reset mid-operation: all in-flight transfers are discarded. err_count clears. Any input presented in the reset cycle is not accepted.

## Test plan
- Basic: N=4, LANES=2, STAGES=2, DATAW=32, data_in={0xD3,0xC2,0xB1,0xA0} (index 3..0), sel lane0=4'b0010, lane1=4'b1000, ready_out=1 -> two cycles later valid_out=1, data_out lane0=0xB1, lane1=0xD3, err_out=2'b00, err_count=0.
- Malformed selects: lane0=4'b0000, lane1=4'b0101 -> lane0 data=0, lane1 data=0xA0|0xC2=0xE2, err_out=2'b11, err_count=1.
- Backpressure: STAGES=3, stream 10 transfers with values 1..10 and ready_out=0 -> ready_in drops after exactly 3 accepts. Then toggle ready_out 1/0 every cycle -> outputs arrive in order 1..10, no duplicates or drops, and data stays stable during stalls.
- Full throughput: ready_out=1, valid_in=1 for 100 cycles -> 100 outputs on consecutive cycles after the STAGES-cycle fill.
- Saturation: CNTW=3, 10 erroneous transfers -> err_count reaches 7 and holds.
- Reset mid-stream: assert reset with 2 transfers in flight -> next cycle valid_out=0, data_out=0, err_count=0, and neither transfer ever appears.
